// File: rtl/sram_rw_sequencer.sv
// Single-port SRAM access sequencer: precharge, word-line access and optional
// sense phases, followed by a valid/ready response handshake.
module sram_rw_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 64,
  parameter int PRE_CYC   = 2,
  parameter int WL_CYC    = 2,
  parameter int SENSE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              precharge_en,
  output logic              wl_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              write_en,
  output logic [DATA_W-1:0] wdrv_data,
  output logic              sense_en,
  input  logic [DATA_W-1:0] sa_data
);

  // state     | meaning
  // IDLE      | ready for a request
  // PRECHARGE | bit lines precharged, word lines off
  // ACCESS    | word line on; write drivers active for writes
  // SENSE     | word line held, sense amps enabled (reads only)
  // RESP      | response valid until accepted
  typedef enum logic [2:0] {IDLE, PRECHARGE, ACCESS, SENSE, RESP} state_t;

  // Counter is loaded with duration-1 on phase entry and the phase ends at zero.
  localparam logic [3:0] PRE_LD   = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LD    = 4'(WL_CYC - 1);
  localparam logic [3:0] SENSE_LD = 4'(SENSE_CYC - 1);

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                cnt_done;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata_q;

  assign cnt_done = (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_valid) state_nxt = PRECHARGE;
      PRECHARGE: if (cnt_done)  state_nxt = ACCESS;
      ACCESS:    if (cnt_done)  state_nxt = we_q ? RESP : SENSE;
      SENSE:     if (cnt_done)  state_nxt = RESP;
      RESP:      if (rsp_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state_nxt != state) begin
        case (state_nxt)
          PRECHARGE: cnt <= PRE_LD;
          ACCESS:    cnt <= WL_LD;
          SENSE:     cnt <= SENSE_LD;
          default:   cnt <= 4'd0;
        endcase
      end else if (!cnt_done) begin
        cnt <= cnt - 4'd1;
      end
      if (state == IDLE && req_valid) begin
        we_q   <= req_we;
        addr_q <= req_addr;
        data_q <= req_wdata;
      end
      if (state == SENSE && cnt_done)
        rdata_q <= sa_data;
      if (state == ACCESS && cnt_done && we_q)
        rdata_q <= '0;
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    precharge_en = 1'b0;
    wl_en        = 1'b0;
    write_en     = 1'b0;
    sense_en     = 1'b0;
    case (state)
      IDLE:      req_ready    = 1'b1;
      PRECHARGE: precharge_en = 1'b1;
      ACCESS: begin
        wl_en    = 1'b1;
        write_en = we_q;
      end
      SENSE: begin
        wl_en    = 1'b1;
        sense_en = 1'b1;
      end
      RESP:      rsp_valid    = 1'b1;
      default:   ;
    endcase
  end

  assign wl_addr   = addr_q;
  assign wdrv_data = write_en ? data_q : '0;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Bench for sram_rw_sequencer: a default-parameter instance and a short-timing
// instance, checked cycle by cycle against a phase-window timing model.
module tb_sram_rw_sequencer;
  localparam int AW = 6;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_we, rsp_ready, sel;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, sa_data;

  logic          d0_req_ready, d0_rsp_valid, d0_precharge_en, d0_wl_en, d0_write_en, d0_sense_en;
  logic [AW-1:0] d0_wl_addr;
  logic [DW-1:0] d0_rsp_rdata, d0_wdrv_data;
  logic          d1_req_ready, d1_rsp_valid, d1_precharge_en, d1_wl_en, d1_write_en, d1_sense_en;
  logic [AW-1:0] d1_wl_addr;
  logic [DW-1:0] d1_rsp_rdata, d1_wdrv_data;

  logic          req_ready, rsp_valid, precharge_en, wl_en, write_en, sense_en;
  logic [AW-1:0] wl_addr;
  logic [DW-1:0] rsp_rdata, wdrv_data;

  sram_rw_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(d0_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d0_rsp_rdata),
    .precharge_en(d0_precharge_en), .wl_en(d0_wl_en), .wl_addr(d0_wl_addr),
    .write_en(d0_write_en), .wdrv_data(d0_wdrv_data), .sense_en(d0_sense_en),
    .sa_data(sa_data));

  sram_rw_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PRE_CYC(1), .WL_CYC(1), .SENSE_CYC(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(d1_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(d1_rsp_rdata),
    .precharge_en(d1_precharge_en), .wl_en(d1_wl_en), .wl_addr(d1_wl_addr),
    .write_en(d1_write_en), .wdrv_data(d1_wdrv_data), .sense_en(d1_sense_en),
    .sa_data(sa_data));

  assign req_ready    = sel ? d1_req_ready    : d0_req_ready;
  assign rsp_valid    = sel ? d1_rsp_valid    : d0_rsp_valid;
  assign precharge_en = sel ? d1_precharge_en : d0_precharge_en;
  assign wl_en        = sel ? d1_wl_en        : d0_wl_en;
  assign write_en     = sel ? d1_write_en     : d0_write_en;
  assign sense_en     = sel ? d1_sense_en     : d0_sense_en;
  assign wl_addr      = sel ? d1_wl_addr      : d0_wl_addr;
  assign rsp_rdata    = sel ? d1_rsp_rdata    : d0_rsp_rdata;
  assign wdrv_data    = sel ? d1_wdrv_data    : d0_wdrv_data;

  int checks = 0;
  int failures = 0;
  int cur_k = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  // Safety properties on both instances, every cycle after the first reset.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("d0 write_en&sense_en", 64'(d0_write_en & d0_sense_en), 64'd0);
      chk("d0 precharge_en&wl_en", 64'(d0_precharge_en & d0_wl_en), 64'd0);
      chk("d0 rsp_valid&req_ready", 64'(d0_rsp_valid & d0_req_ready), 64'd0);
      chk("d1 write_en&sense_en", 64'(d1_write_en & d1_sense_en), 64'd0);
      chk("d1 precharge_en&wl_en", 64'(d1_precharge_en & d1_wl_en), 64'd0);
      chk("d1 rsp_valid&req_ready", 64'(d1_rsp_valid & d1_req_ready), 64'd0);
    end
  end

  // Entered and left just after a negedge in an IDLE cycle. Cycle k counts
  // from the handshake edge; the model is a set of phase windows over k.
  task automatic run_txn(input bit s, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int d, input bit fix_sa);
    int p, w, sc, r, cap_k;
    bit prech, acc, sen, resp, idle;
    logic [DW-1:0] cap;
    p  = s ? 1 : 2;
    w  = s ? 1 : 2;
    sc = s ? 3 : 1;
    r  = we ? p + w + 1 : p + w + sc + 1;
    cap_k = p + w + sc;
    cap = '0;
    sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    rsp_ready = 1'($urandom_range(0, 1));
    cur_k = 0;
    #1 chk("req_ready at handshake", 64'(req_ready), 64'd1);
    for (int k = 1; k <= r + d + 1; k++) begin
      @(negedge clk);
      cur_k = k;
      prech = (k >= 1) && (k <= p);
      acc   = (k > p) && (k <= p + w);
      sen   = !we && (k > p + w) && (k <= p + w + sc);
      resp  = (k >= r) && (k <= r + d);
      idle  = (k == r + d + 1);
      chk("precharge_en", 64'(precharge_en), 64'(prech));
      chk("wl_en", 64'(wl_en), 64'(acc | sen));
      chk("write_en", 64'(write_en), 64'(acc & we));
      chk("sense_en", 64'(sense_en), 64'(sen));
      chk("rsp_valid", 64'(rsp_valid), 64'(resp));
      chk("req_ready", 64'(req_ready), 64'(idle));
      chk("wdrv_data", wdrv_data, (acc && we) ? data : 64'd0);
      if (acc | sen) chk("wl_addr", 64'(wl_addr), 64'(addr));
      if (resp) chk("rsp_rdata", rsp_rdata, we ? 64'd0 : cap);
      req_valid = (k < r + d) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = {$urandom, $urandom};
      rsp_ready = (k < r) ? 1'($urandom_range(0, 1)) : (k >= r + d);
      if (!fix_sa) sa_data = {$urandom, $urandom};
      if (k == cap_k) cap = sa_data;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0; sel = 1'b0;
    req_addr = '0; req_wdata = '0; sa_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset precharge_en", 64'(precharge_en), 64'd0);
    chk("reset wl_en", 64'(wl_en), 64'd0);
    chk("reset write_en", 64'(write_en), 64'd0);
    chk("reset sense_en", 64'(sense_en), 64'd0);
    chk("reset wl_addr", 64'(wl_addr), 64'd0);
    chk("reset wdrv_data", wdrv_data, 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset d1 req_ready", 64'(d1_req_ready), 64'd1);

    run_txn(1'b0, 1'b1, 6'h05, 64'hA5A5_0000_FFFF_1234, 0, 1'b0);
    sa_data = 64'hA5A5_0000_FFFF_1234;
    run_txn(1'b0, 1'b0, 6'h05, 64'h0, 0, 1'b1);
    sa_data = {$urandom, $urandom};
    run_txn(1'b0, 1'b0, 6'h3c, 64'h0, 4, 1'b1);
    run_txn(1'b0, 1'b1, 6'h11, {$urandom, $urandom}, 2, 1'b0);

    // Reset during the ACCESS phase of a write on the default instance.
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h2a;
    req_wdata = {$urandom, $urandom}; rsp_ready = 1'b1;
    cur_k = 0;
    repeat (3) begin
      @(negedge clk);
      cur_k++;
      req_valid = 1'b0;
    end
    chk("abort pre wl_en", 64'(wl_en), 64'd1);
    chk("abort pre write_en", 64'(write_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    cur_k++;
    rst = 1'b0;
    chk("abort wl_en", 64'(wl_en), 64'd0);
    chk("abort write_en", 64'(write_en), 64'd0);
    chk("abort precharge_en", 64'(precharge_en), 64'd0);
    chk("abort req_ready", 64'(req_ready), 64'd1);
    repeat (6) begin
      @(negedge clk);
      cur_k++;
      chk("abort no rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort idle", 64'(req_ready), 64'd1);
    end

    run_txn(1'b1, 1'b0, 6'h21, 64'h0, 0, 1'b0);
    run_txn(1'b1, 1'b1, 6'h0f, {$urandom, $urandom}, 0, 1'b0);
    run_txn(1'b1, 1'b0, 6'h3f, 64'h0, 3, 1'b0);

    for (int i = 0; i < 24; i++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
              {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_rw_sequencer.md
SRAM_RW_SEQUENCER -- requirements
Module: sram_rw_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, row-address width (64 word lines).
REQ-002 SHALL have parameter DATA_W, default 64, word width (bit-line pairs per row).
REQ-003 SHALL have parameter PRE_CYC, default 2, precharge duration in cycles, legal range 1..15.
REQ-004 SHALL have parameter WL_CYC, default 2, word-line-on duration in cycles, legal range 1..15.
REQ-005 SHALL have parameter SENSE_CYC, default 1, sense duration in cycles, legal range 1..15.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit: access request present.
REQ-009 SHALL have port req_ready, output, 1 bit: sequencer can accept a request.
REQ-010 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port req_addr, input, ADDR_W bits: target row.
REQ-012 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-013 SHALL have port rsp_valid, output, 1 bit: access complete.
REQ-014 SHALL have port rsp_ready, input, 1 bit: requester accepts the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits: read data; all zeros for writes.
REQ-016 SHALL have port precharge_en, output, 1 bit: bit-line precharge to 1.
REQ-017 SHALL have port wl_en, output, 1 bit: enable of the decoded word line.
REQ-018 SHALL have port wl_addr, output, ADDR_W bits: row driven to the decoder.
REQ-019 SHALL have port write_en, output, 1 bit: array write enable.
REQ-020 SHALL have port wdrv_data, output, DATA_W bits: data to the bit-line write drivers.
REQ-021 SHALL have port sense_en, output, 1 bit: sense-amp enable.
REQ-022 SHALL have port sa_data, input, DATA_W bits: sense-amp outputs.

Function
REQ-023 SHALL implement the FSM states IDLE, PRECHARGE, ACCESS, SENSE and RESP, using one down-counter of 4 bits.
REQ-024 SHALL drive req_ready=1 only in IDLE; on a handshake (req_valid & req_ready) it SHALL latch req_we, req_addr and req_wdata, then go to PRECHARGE.
REQ-025 In PRECHARGE, SHALL drive precharge_en=1 for exactly PRE_CYC cycles and wl_en, write_en and sense_en all 0; it SHALL then go to ACCESS.
REQ-026 In ACCESS, SHALL drive wl_en=1 and wl_addr=latched address for WL_CYC cycles.
  - Write: write_en=1 and wdrv_data=latched data; next state is RESP.
  - Read: write_en=0 and sense_en=0 so the cells drive the bit lines; next state is SENSE.
REQ-027 In SENSE (reads only), SHALL hold wl_en=1 and drive sense_en=1 for SENSE_CYC cycles, and capture sa_data into rsp_rdata on the last SENSE cycle.
REQ-028 In RESP, SHALL drive rsp_valid=1 and keep rsp_rdata stable until rsp_ready=1; it SHALL then return to IDLE on the next cycle.
REQ-029 Latency, counted from the handshake edge:
  - Write: rsp_valid first high at cycle PRE_CYC+WL_CYC+1 (5 with defaults).
  - Read: rsp_valid first high at cycle PRE_CYC+WL_CYC+SENSE_CYC+1 (6 with defaults).
REQ-030 SHALL never assert write_en and sense_en in the same cycle.
REQ-031 SHALL never assert precharge_en and wl_en in the same cycle.
REQ-032 SHALL hold wl_addr constant whenever wl_en=1.
REQ-033 SHALL drive wdrv_data=0 whenever write_en=0.
REQ-034 SHALL ignore req_valid and request inputs while not in IDLE.
REQ-035 SHALL ignore changes on req_addr and req_wdata after the handshake.
REQ-036 If rsp_ready is already high on the first RESP cycle, SHALL complete the response in one cycle; back-to-back requests are then spaced by one IDLE cycle.
REQ-037 SHALL clear rsp_rdata to 0 when a write completes.

Reset
REQ-038 While rst=1, at each rising edge SHALL go to IDLE and clear the counter and all latched fields.
REQ-039 After reset, outputs SHALL be: req_ready=1; rsp_valid, precharge_en, wl_en, write_en and sense_en all 0; wl_addr, wdrv_data and rsp_rdata all 0.
REQ-040 Reset asserted mid-operation (any state) SHALL deassert every array control on the cycle after the reset edge, and SHALL produce no rsp_valid for the aborted access.

Verification
REQ-041 Write at addr 0x05, data 0xA5A5_0000_FFFF_1234, rsp_ready=1 -> precharge_en high cycles 1-2; wl_en and write_en high cycles 3-4 with wl_addr=5; rsp_valid high cycle 5.
REQ-042 Read at addr 0x05 with sa_data=0xA5A5_0000_FFFF_1234 -> precharge cycles 1-2, wl_en cycles 3-5, sense_en cycle 5, rsp_valid cycle 6 with rsp_rdata equal to sa_data.
REQ-043 Read with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_rdata stable for 5 cycles; req_ready=0 throughout; IDLE entered one cycle after rsp_ready=1.
REQ-044 rst=1 during ACCESS of a write -> next cycle wl_en=0, write_en=0, req_ready=1; no rsp_valid follows.
REQ-045 Every run, checked by assertion: write_en&sense_en, precharge_en&wl_en and rsp_valid&req_ready are never 1; req_valid pulses outside IDLE are ignored.
REQ-046 Parameter sweep with PRE_CYC=1, WL_CYC=1, SENSE_CYC=3 -> read rsp_valid at cycle 6, write rsp_valid at cycle 3.
